// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the simplified MIPS pipeline.
// Owns a word-addressed synchronous data RAM with a fixed access latency of
// WAIT_STATES busy cycles. It performs the load or store of the instruction
// held in EX/MEM and requests a pipeline stall while the access is in flight.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in
//                              control bits from EX/MEM
//   alu_result_in              byte address for loads/stores, ALU result otherwise
//   mem_write_data_in          store data
//   reg_write_address_in       destination register
//   mem_to_reg_out, reg_write_out
//                              control bits to MEM/WB (0 while stalled -> bubble)
//   alu_result_out             pass-through of alu_result_in
//   read_data_out              load data, non-zero only in the completing cycle
//   reg_write_address_out      pass-through of reg_write_address_in
//   mem_stall                  to hazard unit; upstream registers hold while high
//   misaligned                 pulse for an access with alu_result_in[1:0] != 0
//   state_dbg                  current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Stall handshake: mem_stall acts as an inverted ready. While mem_stall=1 the
// EX/MEM register holds its contents stable and MEM/WB captures a bubble; the
// instruction is consumed on the first rising edge where mem_stall=0.

module mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic        mem_write_in,
  input  logic        mem_read_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [4:0]  reg_write_address_in,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] read_data_out,
  output logic [4:0]  reg_write_address_out,
  output logic        mem_stall,
  output logic        misaligned,
  output logic [1:0]  state_dbg
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [31:0]   rdata_q;
  logic [31:0]   ram [DEPTH_WORDS];

  logic          aligned;
  logic          req;
  logic          access;
  logic          is_load;
  logic          commit;
  logic [AW-1:0] idx;

  assign aligned = (alu_result_in[1:0] == 2'b00);
  assign req     = mem_read_in | mem_write_in;
  assign access  = req & aligned;
  // Both read and write set is treated as a store.
  assign is_load = mem_read_in & ~mem_write_in;
  // Upper address bits are ignored, so out-of-range addresses wrap.
  assign idx     = alu_result_in[AW+1:2];
  // A commit edge that coincides with reset is dropped.
  assign commit  = (state == BUSY) && (cnt == 4'd0) && !reset;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            cnt   <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
            if (is_load) rdata_q <= ram[idx];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit && mem_write_in) ram[idx] <= mem_write_data_in;
  end

  always_comb begin
    alu_result_out        = alu_result_in;
    reg_write_address_out = reg_write_address_in;
    reg_write_out         = reg_write_in;
    mem_to_reg_out        = mem_to_reg_in;
    read_data_out         = 32'd0;
    mem_stall             = 1'b0;
    misaligned            = 1'b0;
    if (reset) begin
      reg_write_out  = 1'b0;
      mem_to_reg_out = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            mem_stall      = 1'b1;
            reg_write_out  = 1'b0;
            mem_to_reg_out = 1'b0;
          end else begin
            // Misaligned requests pass through like a non-memory op.
            misaligned = req & ~aligned;
          end
        end
        BUSY: begin
          mem_stall      = 1'b1;
          reg_write_out  = 1'b0;
          mem_to_reg_out = 1'b0;
        end
        DONE: begin
          if (is_load) read_data_out = rdata_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage (DEPTH_WORDS=256,
// WAIT_STATES=2). A transaction-level model turns each instruction into its
// list of expected per-cycle outputs; one compare process checks the DUT
// against that list every cycle, and directed tests add literal checks.

module tb_mem_stage;

  localparam int DEPTH = 256;
  localparam int WAIT  = 2;

  logic        clk;
  logic        reset;
  logic        mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in;
  logic [31:0] alu_result_in, mem_write_data_in;
  logic [4:0]  reg_write_address_in;
  logic        mem_to_reg_out, reg_write_out;
  logic [31:0] alu_result_out, read_data_out;
  logic [4:0]  reg_write_address_out;
  logic        mem_stall, misaligned;
  logic [1:0]  state_dbg;

  mem_stage #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WAIT)) dut (
    .clk                  (clk),
    .reset                (reset),
    .mem_to_reg_in        (mem_to_reg_in),
    .reg_write_in         (reg_write_in),
    .mem_write_in         (mem_write_in),
    .mem_read_in          (mem_read_in),
    .alu_result_in        (alu_result_in),
    .mem_write_data_in    (mem_write_data_in),
    .reg_write_address_in (reg_write_address_in),
    .mem_to_reg_out       (mem_to_reg_out),
    .reg_write_out        (reg_write_out),
    .alu_result_out       (alu_result_out),
    .read_data_out        (read_data_out),
    .reg_write_address_out(reg_write_address_out),
    .mem_stall            (mem_stall),
    .misaligned           (misaligned),
    .state_dbg            (state_dbg)
  );

  // ---------------- clock / reset ----------------
  // Clock starts high so the first falling edge precedes the first rising edge.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  // Entry layout: {stall, misaligned, reg_write, mem_to_reg, alu[32], rdata[32], rwa[5]}
  logic [72:0] exp_q[$];
  logic [31:0] mdl_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stall_run = 0;
  int          last_stall_run = 0;
  logic [31:0] last_rd = 32'd0;
  int          last_rd_cycle = 0;
  logic [72:0] act_v, exp_v;

  function automatic logic [72:0] pk(input logic s, input logic m, input logic rw,
                                     input logic mtr, input logic [31:0] alu,
                                     input logic [31:0] rd, input logic [4:0] a);
    return {s, m, rw, mtr, alu, rd, a};
  endfunction

  always @(negedge clk) begin
    cyc++;
    act_v = pk(mem_stall, misaligned, reg_write_out, mem_to_reg_out,
               alu_result_out, read_data_out, reg_write_address_out);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_outputs cyc=%0d {stall,mis,rw,mtr,alu,rdata,rwa} actual=%h required=%h",
                 cyc, act_v, exp_v);
      end
    end
    if (mem_stall) stall_run++;
    else begin
      if (stall_run > 0) last_stall_run = stall_run;
      stall_run = 0;
    end
    if (read_data_out != 32'd0) begin
      last_rd       = read_data_out;
      last_rd_cycle = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one instruction and queues its expected per-cycle outputs.
  // An aligned access occupies WAIT+2 cycles: WAIT+1 stalled bubbles then a
  // completion cycle carrying the real control bits and load data.
  task automatic issue(input logic rd, input logic wr, input logic rw, input logic mtr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rwa, input int reset_at, output int n);
    int idx;
    logic acc;
    reset                = 1'b0;
    mem_read_in          = rd;
    mem_write_in         = wr;
    reg_write_in         = rw;
    mem_to_reg_in        = mtr;
    alu_result_in        = addr;
    mem_write_data_in    = wdata;
    reg_write_address_in = rwa;
    idx = int'(addr[9:2]);
    acc = (rd | wr) && (addr[1:0] == 2'b00);
    if (!acc) begin
      exp_q.push_back(pk(1'b0, rd | wr, rw, mtr, addr, 32'd0, rwa));
      n = 1;
    end else if (reset_at >= 0) begin
      for (int i = 0; i < reset_at; i++)
        exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, addr, 32'd0, rwa));
      exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, addr, 32'd0, rwa));
      n = reset_at + 1;
    end else begin
      for (int i = 0; i <= WAIT; i++)
        exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 1'b0, addr, 32'd0, rwa));
      exp_q.push_back(pk(1'b0, 1'b0, rw, mtr, addr,
                         (rd && !wr) ? mdl_mem[idx] : 32'd0, rwa));
      if (wr) mdl_mem[idx] = wdata;
      n = WAIT + 2;
    end
  endtask

  task automatic run(input logic rd, input logic wr, input logic rw, input logic mtr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [4:0] rwa, input int reset_at);
    int n;
    issue(rd, wr, rw, mtr, addr, wdata, rwa, reset_at, n);
    if (reset_at >= 0 && n == reset_at + 1) begin
      repeat (reset_at) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
    end else begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    run(1'b0, 1'b1, 1'b0, 1'b0, addr, data, 5'd0, -1);
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] rwa);
    run(1'b1, 1'b0, 1'b1, 1'b1, addr, 32'd0, rwa, -1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, c1, c2, sel;
    logic [31:0] addr;
    logic        r, w;

    // Reset with a live load request on the inputs: outputs must stay quiet.
    reset = 1'b1;
    mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
    alu_result_in = 32'h40; mem_write_data_in = 32'h0; reg_write_address_in = 5'd7;
    for (int i = 0; i < 3; i++)
      exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'd0, 5'd7));
    repeat (3) @(posedge clk);
    #1;

    // Fill the whole RAM so every later load has a known, non-zero value.
    for (int i = 0; i < DEPTH; i++) store(32'(i * 4), $urandom() | 32'h1);

    // Store then load through r5.
    store(32'h10, 32'hDEADBEEF);
    chk("store_stall_cycles", 32'(last_stall_run), 32'd3);
    load(32'h10, 5'd5);
    chk("load_stall_cycles", 32'(last_stall_run), 32'd3);
    chk("load_deadbeef", last_rd, 32'hDEADBEEF);
    chk("model_pin_deadbeef", mdl_mem[4], 32'hDEADBEEF);

    // Non-memory op: same-cycle pass-through.
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h0, 5'd9, -1, n);
    @(negedge clk);
    chk("nop_alu", alu_result_out, 32'h1234);
    chk("nop_rw", 32'(reg_write_out), 32'd1);
    chk("nop_stall", 32'(mem_stall), 32'd0);
    chk("nop_rdata", read_data_out, 32'd0);
    @(posedge clk);
    #1;

    // Misaligned load: one-cycle pulse, no stall, RAM untouched.
    issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0, 5'd3, -1, n);
    @(negedge clk);
    chk("mis_pulse", 32'(misaligned), 32'd1);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    run(1'b0, 1'b1, 1'b0, 1'b0, 32'h12, 32'h0BAD0BAD, 5'd0, -1);  // misaligned store
    load(32'h10, 5'd5);
    chk("after_mis_load", last_rd, 32'hDEADBEEF);

    // Back-to-back loads and address aliasing.
    store(32'h0, 32'h11);
    store(32'h4, 32'h22);
    load(32'h0, 5'd1);
    c1 = last_rd_cycle;
    chk("b2b_first", last_rd, 32'h11);
    load(32'h4, 5'd2);
    c2 = last_rd_cycle;
    chk("b2b_second", last_rd, 32'h22);
    chk("b2b_spacing", 32'(c2 - c1), 32'd4);
    load(32'h400, 5'd3);
    chk("alias_0x400", last_rd, 32'h11);

    // Reset on the final busy cycle of a store drops the write.
    store(32'h8, 32'h0000A5A5);
    run(1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h55, 5'd0, WAIT);
    issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, -1, n);
    @(negedge clk);
    chk("post_reset_stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    load(32'h8, 5'd4);
    chk("reset_drop_store", last_rd, 32'h0000A5A5);
    chk("model_pin_old", mdl_mem[2], 32'h0000A5A5);

    // Read and write both set: behaves as a store.
    run(1'b1, 1'b1, 1'b1, 1'b0, 32'hC, 32'h77, 5'd6, -1);
    load(32'hC, 5'd6);
    chk("both_bits_store", last_rd, 32'h77);

    // Randomized instruction mix.
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1)
        addr = ($urandom() & 32'hFFFF_FFFC);
      else
        addr = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 10);
      r = 1'b0; w = 1'b0;
      case (sel)
        0, 1:    ;
        2, 3, 4: r = 1'b1;
        5, 6, 7: w = 1'b1;
        8:       begin r = 1'b1; w = 1'b1; end
        default: begin
          r = 1'($urandom_range(0, 1));
          w = ~r;
          addr = addr | 32'($urandom_range(1, 3));
        end
      endcase
      run(r, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr,
          $urandom(), 5'($urandom_range(0, 31)), -1);
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the simplified MIPS pipeline, sitting between the EX/MEM and MEM/WB pipeline registers. It owns a word-addressed synchronous data RAM with a fixed, parameterised access latency. It performs loads and stores for the instruction held in EX/MEM and raises a stall request while an access is in flight. Its results go downstream to MEM/WB, with a bubble inserted for every stalled cycle.

## Interface
- DEPTH_WORDS, 256: data RAM depth in 32-bit words; power of two, ≥ 4.
- WAIT_STATES, 2: busy cycles per memory access; legal range 1–15.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in  in  1 each  control bits from EX/MEM.
- alu_result_in  in  32  byte address for loads/stores; ALU result otherwise.
- mem_write_data_in  in  32  store data.
- reg_write_address_in  in  5  destination register.
- mem_to_reg_out, reg_write_out  out  1 each  control bits to MEM/WB; forced to 0 while mem_stall=1.
- alu_result_out  out  32  pass-through of alu_result_in.
- read_data_out  out  32  load data; 0 unless a load completes this cycle.
- reg_write_address_out  out  5  pass-through.
- mem_stall  out  1  to hazard unit; when high, PC, IF/ID, ID/EX and EX/MEM hold.
- misaligned  out  1  one-cycle pulse for an access with alu_result_in[1:0] != 0.

## Operation
- Access = mem_read_in | mem_write_in, qualified by alu_result_in[1:0] == 0.
- RAM index = alu_result_in[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so out-of-range addresses wrap.
- RAM contents are not cleared by reset.
- 4-bit down-counter cnt; FSM states IDLE, BUSY, DONE.
- IDLE, no access: mem_stall=0; outputs are a pure combinational pass-through; read_data_out=0.
- IDLE, access: mem_stall=1; at the edge, cnt←WAIT_STATES−1 and state→BUSY.
- BUSY: mem_stall=1.
  - cnt≠0: cnt decrements.
  - cnt==0: at the edge the access commits and state→DONE. A store writes RAM[index]←mem_write_data_in; a load registers rdata_q←RAM[index].
- DONE: mem_stall=0; outputs carry the real control bits. read_data_out = rdata_q for a load, 0 for a store. At the edge, state→IDLE and EX/MEM advances to the next instruction.
- mem_read_in and mem_write_in both high: treat as a store; read_data_out=0 in DONE.
- Misaligned access: no RAM access and no stall. misaligned=1 for that cycle; the instruction passes through like a non-memory op.
- While mem_stall=1: reg_write_out=0 and mem_to_reg_out=0, so MEM/WB captures a bubble.

## Timing
- Non-memory instruction: 1 cycle in MEM, no stall.
- Load or store: WAIT_STATES+2 cycles in MEM (IDLE, then WAIT_STATES×BUSY, then DONE), with mem_stall high for WAIT_STATES+1 consecutive cycles.
- Load data is valid on read_data_out only in the DONE cycle and is captured by MEM/WB at the end of that cycle.
- The store write is visible to a load that enters IDLE on the next cycle or later.
- Back-to-back memory instructions: the second enters IDLE the cycle after DONE. No dead cycle beyond WAIT_STATES+2 each.
- Reset:
  - At any edge with reset=1, state→IDLE, cnt←0, rdata_q←0.
  - A store whose commit edge coincides with reset is not written.
  - While reset=1, mem_stall=0, misaligned=0, read_data_out=0, reg_write_out=0, mem_to_reg_out=0.
- Inputs must be held stable by EX/MEM while mem_stall=1. The hazard unit guarantees this; the block does not re-sample its inputs.

## Test plan
- WAIT_STATES=2. Store 0xDEADBEEF to 0x10, then load from 0x10 into r5. Required: mem_stall high for 3 cycles per op. Load DONE cycle shows read_data_out=0xDEADBEEF, reg_write_out=1, reg_write_address_out=5. Each op takes 4 cycles.
- Non-memory op with alu_result_in=0x1234 and reg_write_in=1. Required: same cycle, alu_result_out=0x1234, reg_write_out=1, mem_stall=0, read_data_out=0.
- Load from 0x13. Required: misaligned=1 for one cycle, mem_stall=0, no RAM access. A following load from 0x10 still returns the prior value.
- Two back-to-back loads, from 0x0 (0x11) and 0x4 (0x22), with DEPTH_WORDS=256. Required: DONE cycles 4 cycles apart, returning 0x11 then 0x22. A load from 0x400 aliases index 0 and returns 0x11.
- Reset asserted on the final BUSY cycle of a store of 0x55 to 0x8. Required: the next cycle is IDLE with mem_stall=0, and a subsequent load from 0x8 returns the old contents, not 0x55.
- mem_read_in=mem_write_in=1, 0x77 to 0xC. Required: treated as a store; read_data_out=0 in DONE; a later load from 0xC returns 0x77.
